// File: rtl/speaker_envelope_pkg.sv
// Shared state codes, timing constants and amplitude helper for speaker_envelope.
package speaker_envelope_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  localparam logic [7:0] ENV_MAX = 8'hFF;
  localparam int T_1MS  = 12000;
  localparam int T_10MS = 120000;

  // Scale the envelope by volume/16; keeps the upper byte of the 12-bit product.
  function automatic logic [7:0] env_amp(input logic [7:0] env, input logic [3:0] vol);
    logic [11:0] prod;
    prod = 12'(env) * 12'(vol);
    return prod[11:4];
  endfunction

endpackage

// File: rtl/speaker_envelope_tone_period_meter.sv
// Measures cycles between rising edges of the registered tone (saturating 16-bit).
// Only built when ENV_RETRIGGER_EN is defined.
`ifdef ENV_RETRIGGER_EN
module tone_period_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_q,
  output logic        rise,
  output logic [15:0] period,
  output logic        period_valid
);

  logic        tone_d;
  logic        seen;
  logic [15:0] cnt;

  assign rise         = tone_q & ~tone_d;
  assign period       = cnt;
  // The first rise after reset has no reference interval, so it only seeds the stored period.
  assign period_valid = rise & seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_d <= 1'b0;
      seen   <= 1'b0;
      cnt    <= '0;
    end else begin
      tone_d <= tone_q;
      if (rise) begin
        seen <= 1'b1;
        cnt  <= 16'd1;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/speaker_envelope.sv
// Attack/sustain/release envelope with volume and PWM output for the tone generator.
// Optional pitch-change retrigger is enabled by defining ENV_RETRIGGER_EN.
module speaker_envelope
  import speaker_envelope_pkg::*;
#(
  parameter int SILENCE_TIMEOUT = T_10MS,
  parameter int ENV_STEP        = T_1MS,
  parameter int ATTACK_INC      = 32,
  parameter int RELEASE_DEC     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  input  logic [3:0] volume,
  output logic       speaker_pwm,
  output logic       active
);

  localparam int IW = $clog2(SILENCE_TIMEOUT + 1);
  localparam int SW = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

  env_state_t    state, next_state;
  logic [7:0]    env, next_env;
  logic          tone_q;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] step_cnt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    amp;
  logic [8:0]    env_up, env_dn;
  logic [7:0]    env_up_sat, env_dn_sat;
  logic          tone_edge, silent, step, retrig, entry;

  assign tone_edge  = tone_in ^ tone_q;
  // An edge in the same cycle as the timeout keeps the tone alive.
  assign silent     = (idle_cnt == IW'(SILENCE_TIMEOUT)) && !tone_edge;
  assign step       = (step_cnt == SW'(ENV_STEP - 1));
  assign env_up     = {1'b0, env} + 9'(ATTACK_INC);
  assign env_dn     = {1'b0, env} - 9'(RELEASE_DEC);
  assign env_up_sat = env_up[8] ? ENV_MAX : env_up[7:0];
  assign env_dn_sat = env_dn[8] ? 8'd0 : env_dn[7:0];
  assign amp        = env_amp(env, volume);

`ifdef ENV_RETRIGGER_EN
  logic        rise, period_valid;
  logic [15:0] period, last_period, period_diff;

  tone_period_meter u_meter (
    .clk         (clk),
    .rst         (rst),
    .tone_q      (tone_q),
    .rise        (rise),
    .period      (period),
    .period_valid(period_valid)
  );

  assign period_diff = (period > last_period) ? period - last_period : last_period - period;
  // A period shift beyond 1/8 of the previous one is treated as a new note.
  assign retrig      = period_valid && (period_diff > (last_period >> 3));

  always_ff @(posedge clk) begin
    if (rst)       last_period <= '0;
    else if (rise) last_period <= period;
  end
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    next_state = state;
    next_env   = env;
    unique case (state)
      ENV_IDLE: begin
        next_env = 8'd0;
        if (tone_edge) next_state = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (silent) next_state = ENV_RELEASE;
        else if (step) begin
          next_env = env_up_sat;
          if (env_up_sat == ENV_MAX) next_state = ENV_SUSTAIN;
        end
      end
      ENV_SUSTAIN: begin
        next_env = ENV_MAX;
        if (silent) next_state = ENV_RELEASE;
      end
      ENV_RELEASE: begin
        if (tone_edge) next_state = ENV_ATTACK;
        else if (step) begin
          next_env = env_dn_sat;
          if (env_dn_sat == 8'd0) next_state = ENV_IDLE;
        end
      end
      default: next_state = ENV_IDLE;
    endcase
    if (retrig) begin
      next_state = ENV_ATTACK;
      next_env   = env >> 1;
    end
  end

  assign entry = (next_state != state) || retrig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENV_IDLE;
      env         <= '0;
      tone_q      <= 1'b0;
      idle_cnt    <= '0;
      step_cnt    <= '0;
      pwm_cnt     <= '0;
      speaker_pwm <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= next_state;
      env         <= next_env;
      active      <= (next_state != ENV_IDLE);
      tone_q      <= tone_in;
      pwm_cnt     <= pwm_cnt + 8'd1;
      speaker_pwm <= tone_q & (pwm_cnt < amp);
      if (tone_edge)                          idle_cnt <= '0;
      else if (idle_cnt != IW'(SILENCE_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
      if (entry || step) step_cnt <= '0;
      else               step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule
